pwm_multichannel_gen: RTL and testbench

Parametrised multi-channel PWM generator. Successor to the single-channel 6-bit duty-cycle counter. One shared period counter drives N independent duty comparators. Period and duty values are double-buffered and take effect only at period boundaries, so outputs never glitch. Both edge-aligned and centre-aligned modes are supported. Sits between the control/register logic (which drives Period/Duty) and the power-stage drivers.

---
 rtl/pwm_multichannel_gen_if.sv | 24 ++
 rtl/pwm_multichannel_gen.sv | 100 ++++++++++
 tb/tb_pwm_multichannel_gen.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pwm_multichannel_gen_if.sv
// Control/output bundle for the multichannel PWM generator.
// The register side drives period, duty and polarity; the power stage observes the outputs.
interface pwm_multichannel_gen_if #(
  parameter int W = 8,
  parameter int N = 4
);
  logic           i_en;
  logic [W-1:0]   i_period;
  logic [N*W-1:0] i_duty;
  logic [N-1:0]   i_pol;
  logic [N-1:0]   o_pwmOut;
  logic [W-1:0]   o_cnt;
  logic           o_periodEnd;

  modport master (
    output i_en, i_period, i_duty, i_pol,
    input  o_pwmOut, o_cnt, o_periodEnd
  );

  modport slave (
    input  i_en, i_period, i_duty, i_pol,
    output o_pwmOut, o_cnt, o_periodEnd
  );
endinterface

// File: rtl/pwm_multichannel_gen.sv
// Multichannel PWM generator: one shared period counter feeds N duty comparators.
// Period and duty are double-buffered, so they only change at period boundaries.
module pwm_multichannel_gen #(
  parameter int W          = 8,
  parameter int N          = 4,
  parameter int MODE       = 0,
  parameter int DEF_PERIOD = 50
) (
  input logic                   clk,
  input logic                   rst_n,
  pwm_multichannel_gen_if.slave bus
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cntNext;
  logic [W-1:0] r_pAct;
  logic [W-1:0] r_dAct [N];
  dir_e         r_dir;
  dir_e         w_dirNext;
  logic         w_boundary;
  logic [N-1:0] r_pwm;
  logic         r_periodEnd;

  always_comb begin
    w_boundary = 1'b0;
    if (bus.i_en) begin
      if (MODE == 0) begin
        w_boundary = (r_cnt == r_pAct);
      end else begin
        w_boundary = (r_dir == DIR_DOWN && r_cnt == W'(1)) ||
                     (r_dir == DIR_UP && r_pAct == W'(1) && r_cnt == W'(1)) ||
                     (r_pAct == '0);
      end
    end
  end

  // Centre-aligned mode turns around at P_act and goes back up once it returns to 0.
  always_comb begin
    w_cntNext = '0;
    w_dirNext = DIR_UP;
    if (bus.i_en) begin
      if (MODE == 0) begin
        w_cntNext = (r_cnt == r_pAct) ? '0 : r_cnt + 1'b1;
      end else if (r_pAct != '0) begin
        if (r_dir == DIR_UP && r_cnt < r_pAct) begin
          w_cntNext = r_cnt + 1'b1;
        end else begin
          w_cntNext = r_cnt - 1'b1;
        end
        if (w_cntNext == '0) begin
          w_dirNext = DIR_UP;
        end else if (r_cnt >= r_pAct) begin
          w_dirNext = DIR_DOWN;
        end else begin
          w_dirNext = r_dir;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else begin
      r_cnt <= w_cntNext;
      r_dir <= w_dirNext;
    end
  end

  // While disabled the buffers track the inputs, so the first enabled period uses fresh values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pAct      <= W'(DEF_PERIOD);
      r_pwm       <= '0;
      r_periodEnd <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_dAct[i] <= '0;
      end
    end else begin
      r_periodEnd <= w_boundary;
      if (!bus.i_en || w_boundary) begin
        r_pAct <= bus.i_period;
        for (int i = 0; i < N; i++) begin
          r_dAct[i] <= bus.i_duty[i*W +: W];
        end
      end
      for (int i = 0; i < N; i++) begin
        r_pwm[i] <= bus.i_en ? ((r_cnt < r_dAct[i]) ^ bus.i_pol[i]) : bus.i_pol[i];
      end
    end
  end

  assign bus.o_cnt       = r_cnt;
  assign bus.o_pwmOut    = r_pwm;
  assign bus.o_periodEnd = r_periodEnd;

endmodule

// File: tb/tb_pwm_multichannel_gen.sv
// Directed bench for pwm_multichannel_gen: an edge-aligned instance and a centre-aligned instance,
// both with W=8, N=2, checked against hand-derived cycle-by-cycle expectations.
module tb_pwm_multichannel_gen;

  logic clk;
  logic rst_n;
  int   checksTotal;
  int   checksPassed;
  int   seq1 [8];

  pwm_multichannel_gen_if #(.W(8), .N(2)) if0 ();
  pwm_multichannel_gen_if #(.W(8), .N(2)) if1 ();

  pwm_multichannel_gen #(.W(8), .N(2), .MODE(0), .DEF_PERIOD(50)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  pwm_multichannel_gen #(.W(8), .N(2), .MODE(1), .DEF_PERIOD(50)) u_centre (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  // Clock with rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checksTotal++;
    if (observed == expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] period,
                               input logic [7:0] duty0, input logic [7:0] duty1,
                               input logic [1:0] pol);
    if0.i_en     = en;
    if0.i_period = period;
    if0.i_duty   = {duty1, duty0};
    if0.i_pol    = pol;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    seq1         = '{0, 1, 2, 3, 4, 3, 2, 1};
    rst_n        = 1'b1;
    applyStimulus(1'b0, 8'd9, 8'd3, 8'd0, 2'b00);
    if1.i_en     = 1'b0;
    if1.i_period = 8'd4;
    if1.i_duty   = {8'd0, 8'd2};
    if1.i_pol    = 2'b00;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset cnt", int'(if0.o_cnt), 0);
    checkOutput("reset pwm", int'(if0.o_pwmOut), 0);
    checkOutput("reset periodEnd", int'(if0.o_periodEnd), 0);
    checkOutput("reset centre cnt", int'(if1.o_cnt), 0);
    repeat (2) stepClock();
    rst_n = 1'b1;
    stepClock();
    checkOutput("disabled pwm", int'(if0.o_pwmOut), 0);

    // Edge-aligned, period 10, duty 3 / 0
    applyStimulus(1'b1, 8'd9, 8'd3, 8'd0, 2'b00);
    for (int k = 1; k <= 20; k++) begin
      stepClock();
      checkOutput($sformatf("t1 cnt k=%0d", k), int'(if0.o_cnt), k % 10);
      checkOutput($sformatf("t1 pwm0 k=%0d", k), int'(if0.o_pwmOut[0]), int'(((k - 1) % 10) < 3));
      checkOutput($sformatf("t1 pwm1 k=%0d", k), int'(if0.o_pwmOut[1]), 0);
      checkOutput($sformatf("t1 periodEnd k=%0d", k), int'(if0.o_periodEnd), int'((k % 10) == 0));
    end

    // Duty change mid-period only applies after the next boundary
    for (int k = 21; k <= 25; k++) stepClock();
    checkOutput("t2 cnt before change", int'(if0.o_cnt), 5);
    applyStimulus(1'b1, 8'd9, 8'd7, 8'd0, 2'b00);
    for (int k = 26; k <= 40; k++) begin
      stepClock();
      checkOutput($sformatf("t2 pwm0 k=%0d", k), int'(if0.o_pwmOut[0]), int'(k >= 31 && k <= 37));
    end

    // Duty above period is always active; polarity acts on the next clock
    applyStimulus(1'b1, 8'd9, 8'd10, 8'd0, 2'b00);
    for (int k = 41; k <= 50; k++) stepClock();
    for (int k = 51; k <= 60; k++) begin
      stepClock();
      checkOutput($sformatf("t3 pwm0 full k=%0d", k), int'(if0.o_pwmOut[0]), 1);
    end
    applyStimulus(1'b1, 8'd9, 8'd10, 8'd0, 2'b01);
    for (int k = 61; k <= 65; k++) begin
      stepClock();
      checkOutput($sformatf("t3 pwm0 inverted k=%0d", k), int'(if0.o_pwmOut[0]), 0);
    end
    applyStimulus(1'b1, 8'd9, 8'd10, 8'd0, 2'b00);

    // Enable dropped at cnt 6, then restart with period 4 / duty 2
    stepClock();
    checkOutput("t5 cnt before disable", int'(if0.o_cnt), 6);
    checkOutput("t5 pwm0 before disable", int'(if0.o_pwmOut[0]), 1);
    applyStimulus(1'b0, 8'd9, 8'd10, 8'd0, 2'b10);
    stepClock();
    checkOutput("t5 disabled cnt", int'(if0.o_cnt), 0);
    checkOutput("t5 disabled pwm", int'(if0.o_pwmOut), 2);
    checkOutput("t5 disabled periodEnd", int'(if0.o_periodEnd), 0);
    applyStimulus(1'b0, 8'd3, 8'd2, 8'd0, 2'b00);
    stepClock();
    checkOutput("t5 disabled pwm pol0", int'(if0.o_pwmOut), 0);
    applyStimulus(1'b1, 8'd3, 8'd2, 8'd0, 2'b00);
    for (int j = 1; j <= 8; j++) begin
      stepClock();
      checkOutput($sformatf("t5 cnt j=%0d", j), int'(if0.o_cnt), j % 4);
      checkOutput($sformatf("t5 pwm0 j=%0d", j), int'(if0.o_pwmOut[0]), int'((j % 4) == 1 || (j % 4) == 2));
      checkOutput($sformatf("t5 periodEnd j=%0d", j), int'(if0.o_periodEnd), int'((j % 4) == 0));
    end

    // Asynchronous reset mid-period, then a 51-cycle period from DEF_PERIOD
    applyStimulus(1'b1, 8'd9, 8'd9, 8'd0, 2'b00);
    repeat (9) stepClock();
    checkOutput("t6 cnt before reset", int'(if0.o_cnt), 5);
    checkOutput("t6 pwm0 before reset", int'(if0.o_pwmOut[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6 async cnt", int'(if0.o_cnt), 0);
    checkOutput("t6 async pwm", int'(if0.o_pwmOut), 0);
    checkOutput("t6 async periodEnd", int'(if0.o_periodEnd), 0);
    stepClock();
    #2 rst_n = 1'b1;
    for (int j = 1; j <= 61; j++) begin
      stepClock();
      checkOutput($sformatf("t6 cnt j=%0d", j), int'(if0.o_cnt), (j <= 50) ? j : (j - 51) % 10);
      checkOutput($sformatf("t6 periodEnd j=%0d", j), int'(if0.o_periodEnd), int'(j == 51 || j == 61));
      checkOutput($sformatf("t6 pwm0 j=%0d", j), int'(if0.o_pwmOut[0]), int'(j >= 52 && j <= 60));
    end

    // Centre-aligned, period 4, duty 2
    if1.i_en = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      stepClock();
      checkOutput($sformatf("t4 cnt j=%0d", j), int'(if1.o_cnt), seq1[j % 8]);
      checkOutput($sformatf("t4 pwm0 j=%0d", j), int'(if1.o_pwmOut[0]), int'((j % 8) <= 2));
      checkOutput($sformatf("t4 pwm1 j=%0d", j), int'(if1.o_pwmOut[1]), 0);
      checkOutput($sformatf("t4 periodEnd j=%0d", j), int'(if1.o_periodEnd), int'((j % 8) == 0));
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
